// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for the single-port RAM: turns whole-word
// read/write requests into the RAM's two-beat opcode command stream.
module ram_port_arbiter #(
  parameter int MEM_WIDTH  = 8,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p1_req,
  input  logic                 p0_we,
  input  logic                 p1_we,
  input  logic [MEM_WIDTH-1:0] p0_addr,
  input  logic [MEM_WIDTH-1:0] p1_addr,
  input  logic [MEM_WIDTH-1:0] p0_wdata,
  input  logic [MEM_WIDTH-1:0] p1_wdata,
  output logic                 p0_ack,
  output logic                 p1_ack,
  output logic [MEM_WIDTH-1:0] p0_rdata,
  output logic [MEM_WIDTH-1:0] p1_rdata,
  output logic                 p0_err,
  output logic                 p1_err,
  output logic                 busy,
  output logic [MEM_WIDTH+1:0] ram_din,
  output logic                 ram_rx_valid,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CMD, RD_WAIT, DONE
  } state_e;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD      = 2'b11;
  localparam logic [3:0] TIMEOUT_C  = 4'(RD_TIMEOUT);

  state_e                 state_q;
  logic                   grant_q;
  logic                   last_grant_q;
  logic [MEM_WIDTH-1:0]   wdata_q;
  logic [3:0]             cnt_q;
  logic [MEM_WIDTH+1:0]   ram_din_q;
  logic                   ram_rx_valid_q;
  logic                   busy_q;
  logic                   p0_ack_q, p1_ack_q;
  logic                   p0_err_q, p1_err_q;
  logic [MEM_WIDTH-1:0]   p0_rdata_q, p1_rdata_q;

  // Port 1 wins when it is the only requester or when port 0 had the last grant.
  logic                   grant_d;
  logic                   sel_we;
  logic [MEM_WIDTH-1:0]   sel_addr;
  logic [MEM_WIDTH-1:0]   sel_wdata;

  assign grant_d   = p1_req & (~p0_req | ~last_grant_q);
  assign sel_we    = grant_d ? p1_we    : p0_we;
  assign sel_addr  = grant_d ? p1_addr  : p0_addr;
  assign sel_wdata = grant_d ? p1_wdata : p0_wdata;

  // NOTE: non-blocking assignments so every register samples pre-edge values;
  // outputs are loaded one state early so they are registered yet on time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      wdata_q        <= '0;
      cnt_q          <= '0;
      ram_din_q      <= '0;
      ram_rx_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      p0_ack_q       <= 1'b0;
      p1_ack_q       <= 1'b0;
      p0_err_q       <= 1'b0;
      p1_err_q       <= 1'b0;
      p0_rdata_q     <= '0;
      p1_rdata_q     <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      p0_err_q <= 1'b0;
      p1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            grant_q        <= grant_d;
            last_grant_q   <= grant_d;
            wdata_q        <= sel_wdata;
            ram_rx_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            if (sel_we) begin
              state_q   <= WR_ADDR;
              ram_din_q <= {OP_WR_ADDR, sel_addr};
            end else begin
              state_q   <= RD_ADDR;
              ram_din_q <= {OP_RD_ADDR, sel_addr};
            end
          end
        end
        WR_ADDR: begin
          state_q   <= WR_DATA;
          ram_din_q <= {OP_WR_DATA, wdata_q};
        end
        WR_DATA: begin
          state_q        <= DONE;
          ram_din_q      <= '0;
          ram_rx_valid_q <= 1'b0;
          if (grant_q) p1_ack_q <= 1'b1;
          else         p0_ack_q <= 1'b1;
        end
        RD_ADDR: begin
          state_q   <= RD_CMD;
          ram_din_q <= {OP_RD, {MEM_WIDTH{1'b0}}};
        end
        RD_CMD: begin
          state_q        <= RD_WAIT;
          ram_din_q      <= '0;
          ram_rx_valid_q <= 1'b0;
          cnt_q          <= '0;
        end
        RD_WAIT: begin
          if (ram_tx_valid) begin
            state_q <= DONE;
            if (grant_q) begin
              p1_rdata_q <= ram_dout;
              p1_ack_q   <= 1'b1;
            end else begin
              p0_rdata_q <= ram_dout;
              p0_ack_q   <= 1'b1;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            // Timed out: hand back zero data with the error flag alongside the ack.
            state_q <= DONE;
            if (grant_q) begin
              p1_rdata_q <= '0;
              p1_ack_q   <= 1'b1;
              p1_err_q   <= 1'b1;
            end else begin
              p0_rdata_q <= '0;
              p0_ack_q   <= 1'b1;
              p0_err_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q        <= IDLE;
          ram_din_q      <= '0;
          ram_rx_valid_q <= 1'b0;
          busy_q         <= 1'b0;
        end
      endcase
    end
  end

  assign ram_din      = ram_din_q;
  assign ram_rx_valid = ram_rx_valid_q;
  assign busy         = busy_q;
  assign p0_ack       = p0_ack_q;
  assign p1_ack       = p1_ack_q;
  assign p0_err       = p0_err_q;
  assign p1_err       = p1_err_q;
  assign p0_rdata     = p0_rdata_q;
  assign p1_rdata     = p1_rdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM, a per-cycle timeline model of
// the expected outputs, and directed transactions with literal expectations.
module tb_ram_port_arbiter;

  localparam int MW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_req = 1'b0, p1_req = 1'b0;
  logic          p0_we = 1'b0, p1_we = 1'b0;
  logic [MW-1:0] p0_addr = '0, p1_addr = '0;
  logic [MW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ack, p1_ack, p0_err, p1_err, busy;
  logic [MW-1:0] p0_rdata, p1_rdata;
  logic [MW+1:0] ram_din;
  logic          ram_rx_valid;
  logic [MW-1:0] ram_dout = '0;
  logic          ram_tx_valid = 1'b0;

  ram_port_arbiter #(.MEM_WIDTH(MW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_ack(p0_ack), .p1_ack(p1_ack), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .p0_err(p0_err), .p1_err(p1_err), .busy(busy),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural single-port RAM ----------------
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wr_addr = '0, ram_rd_addr = '0;
  logic       rd_pending = 1'b0;
  logic       ram_stall = 1'b0;

  always @(negedge clk) begin
    ram_tx_valid = rd_pending;
    ram_dout     = rd_pending ? ram_mem[ram_rd_addr] : 8'h00;
    rd_pending   = 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00: ram_wr_addr = ram_din[7:0];
        2'b01: ram_mem[ram_wr_addr] = ram_din[7:0];
        2'b10: ram_rd_addr = ram_din[7:0];
        default: rd_pending = !ram_stall;
      endcase
    end
  end

  // ---------------- timeline model ----------------
  typedef struct packed {
    logic       busy;
    logic       rxv;
    logic [9:0] din;
    logic       ack0, ack1, err0, err1;
    logic       upd;
    logic       rport;
    logic [7:0] rval;
    logic       do_wr;
    logic [7:0] wa;
    logic [7:0] wd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_mem [256];
  logic [7:0] m_rdata0 = '0, m_rdata1 = '0;
  logic       m_last = 1'b1;
  int         ack_order[$];
  logic [9:0] din_log[$];

  initial for (int i = 0; i < 256; i++) begin
    ram_mem[i] = '0;
    m_mem[i]   = '0;
  end

  function automatic exp_t busy_e();
    exp_t e = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Expected output for each cycle T1.. of one granted transaction.
  function automatic void push_txn(input logic port, input logic we, input logic [7:0] addr,
                                   input logic [7:0] wdata, input logic stall);
    exp_t e;
    e = busy_e(); e.rxv = 1'b1; e.din = {(we ? 2'b00 : 2'b10), addr};
    exp_q.push_back(e);
    if (we) begin
      e = busy_e(); e.rxv = 1'b1; e.din = {2'b01, wdata};
      e.do_wr = 1'b1; e.wa = addr; e.wd = wdata;
      exp_q.push_back(e);
      e = busy_e();
      if (port) e.ack1 = 1'b1; else e.ack0 = 1'b1;
      exp_q.push_back(e);
    end else begin
      e = busy_e(); e.rxv = 1'b1; e.din = {2'b11, 8'h00};
      exp_q.push_back(e);
      for (int i = 0; i < (stall ? TO + 1 : 1); i++) exp_q.push_back(busy_e());
      e = busy_e();
      if (port) begin e.ack1 = 1'b1; e.err1 = stall; end
      else      begin e.ack0 = 1'b1; e.err0 = stall; end
      e.upd = 1'b1; e.rport = port; e.rval = stall ? 8'h00 : m_mem[addr];
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin : compare
    exp_t e;
    logic was_idle;
    logic win;
    e = '0;
    if (!rst_n) begin
      exp_q.delete();
      m_rdata0 = '0;
      m_rdata1 = '0;
      m_last   = 1'b1;
    end
    was_idle = (exp_q.size() == 0);
    if (!was_idle) e = exp_q.pop_front();
    if (e.do_wr) m_mem[e.wa] = e.wd;
    if (e.upd) begin
      if (e.rport) m_rdata1 = e.rval;
      else         m_rdata0 = e.rval;
    end
    check("ram_din",      32'(ram_din),      32'(e.din));
    check("ram_rx_valid", 32'(ram_rx_valid), 32'(e.rxv));
    check("busy",         32'(busy),         32'(e.busy));
    check("p0_ack",       32'(p0_ack),       32'(e.ack0));
    check("p1_ack",       32'(p1_ack),       32'(e.ack1));
    check("p0_err",       32'(p0_err),       32'(e.err0));
    check("p1_err",       32'(p1_err),       32'(e.err1));
    check("p0_rdata",     32'(p0_rdata),     32'(m_rdata0));
    check("p1_rdata",     32'(p1_rdata),     32'(m_rdata1));
    if (ram_rx_valid) din_log.push_back(ram_din);
    if (p0_ack) ack_order.push_back(0);
    if (p1_ack) ack_order.push_back(1);
    if (rst_n && was_idle && (p0_req || p1_req)) begin
      win    = (p0_req && p1_req) ? !m_last : p1_req;
      m_last = win;
      push_txn(win, win ? p1_we : p0_we, win ? p1_addr : p0_addr,
               win ? p1_wdata : p0_wdata, ram_stall);
    end
  end

  // ---------------- requester ----------------
  task automatic do_txn(input int port, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, output int lat, output logic [7:0] rd,
                        output logic er);
    int   t0;
    logic got;
    got = 1'b0; lat = -1; rd = '0; er = 1'b0;
    if (port == 0) begin p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1; end
    else           begin p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1; end
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (port == 0 ? p0_ack : p1_ack) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = (port == 0) ? p0_rdata : p1_rdata;
        er  = (port == 0) ? p0_err : p1_err;
        break;
      end
    end
    check($sformatf("p%0d_ack_seen", port), 32'(got), 32'd1);
    @(posedge clk); #1;
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
  endtask

  int         lat, lat_b;
  logic [7:0] rd, rd_b;
  logic       er, er_b;

  initial begin
    #1;
    // Reset with both requests pending.
    rst_n = 1'b0;
    p0_we = 1'b1; p0_addr = 8'h05; p0_wdata = 8'h55; p0_req = 1'b1;
    p1_we = 1'b1; p1_addr = 8'h06; p1_wdata = 8'h66; p1_req = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rxv",  32'(ram_rx_valid), 32'd0);
    check("rst_din",  32'(ram_din), 32'd0);
    check("rst_acks", 32'({p0_ack, p1_ack, p0_err, p1_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ack_order.delete();
    fork
      do_txn(0, 1'b1, 8'h05, 8'h55, lat, rd, er);
      do_txn(1, 1'b1, 8'h06, 8'h66, lat_b, rd_b, er_b);
    join
    check("first_grant_port", 32'(ack_order.size() > 0 ? ack_order[0] : -1), 32'd0);

    // Write then read on port 0.
    din_log.delete();
    do_txn(0, 1'b1, 8'h3C, 8'hA5, lat, rd, er);
    check("wr_ack_latency", 32'(lat), 32'd3);
    do_txn(0, 1'b0, 8'h3C, 8'h00, lat, rd, er);
    check("rd_ack_latency", 32'(lat), 32'd4);
    check("rd_data_3c", 32'(rd), 32'hA5);
    check("din_log_len", 32'(din_log.size()), 32'd4);
    if (din_log.size() == 4) begin
      check("din_0", 32'(din_log[0]), 32'h03C);
      check("din_1", 32'(din_log[1]), 32'h1A5);
      check("din_2", 32'(din_log[2]), 32'h23C);
      check("din_3", 32'(din_log[3]), 32'h300);
    end

    // Read timeout on port 1.
    ram_stall = 1'b1;
    do_txn(1, 1'b0, 8'h10, 8'h00, lat, rd, er);
    ram_stall = 1'b0;
    check("to_ack_latency", 32'(lat), 32'd8);
    check("to_err", 32'(er), 32'd1);
    check("to_rdata", 32'(rd), 32'd0);

    // Both ports hammering writes.
    ack_order.delete();
    fork
      begin
        do_txn(0, 1'b1, 8'h01, 8'h11, lat, rd, er);
        do_txn(0, 1'b1, 8'h01, 8'h11, lat, rd, er);
      end
      begin
        do_txn(1, 1'b1, 8'h02, 8'h22, lat_b, rd_b, er_b);
        do_txn(1, 1'b1, 8'h02, 8'h22, lat_b, rd_b, er_b);
      end
    join
    check("rr_ack_count", 32'(ack_order.size()), 32'd4);
    if (ack_order.size() == 4) begin
      check("rr_order", 32'({ack_order[0][0], ack_order[1][0], ack_order[2][0], ack_order[3][0]}),
            32'b0101);
    end
    do_txn(0, 1'b0, 8'h01, 8'h00, lat, rd, er);
    check("rr_read_01", 32'(rd), 32'h11);
    do_txn(0, 1'b0, 8'h02, 8'h00, lat, rd, er);
    check("rr_read_02", 32'(rd), 32'h22);

    // Reset while the write-data beat is on the bus.
    ack_order.delete();
    p0_we = 1'b1; p0_addr = 8'h50; p0_wdata = 8'h77; p0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_wr_data", 32'(ram_din), 32'h177);
    rst_n  = 1'b0;
    p0_req = 1'b0;
    #1;
    check("abort_rxv_drop", 32'(ram_rx_valid), 32'd0);
    check("abort_din_zero", 32'(ram_din), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(ack_order.size()), 32'd0);
    @(posedge clk); #1;
    do_txn(0, 1'b1, 8'h50, 8'h77, lat, rd, er);
    check("post_rst_wr_latency", 32'(lat), 32'd3);
    do_txn(0, 1'b0, 8'h50, 8'h00, lat, rd, er);
    check("post_rst_read", 32'(rd), 32'h77);

    // Address extremes.
    do_txn(0, 1'b1, 8'hFF, 8'hFF, lat, rd, er);
    do_txn(0, 1'b0, 8'h00, 8'h00, lat, rd, er);
    check("read_addr_00", 32'(rd), 32'h00);
    do_txn(0, 1'b0, 8'hFF, 8'h00, lat, rd, er);
    check("read_addr_ff", 32'(rd), 32'hFF);
    check("read_ff_err", 32'(er), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
